// File: rtl/adler32_chk_pkg.sv
// Shared types and constants for the Adler-32 zlib trailer checker.
package adler32_chk_pkg;

  localparam int unsigned DATA_WD  = 32;
  localparam int unsigned MOD_BASE = 65521;

  typedef enum logic [2:0] {
    IDLE,
    ACTV,
    PROC,
    CHK,
    DONE
  } state_t;

  // Running checksum halves, packed as {s2,s1} to match the trailer layout
  typedef struct packed {
    logic [15:0] s2;
    logic [15:0] s1;
  } adler32_s_t;

endpackage

// File: rtl/adler32_byte_step.sv
// One Adler-32 byte update: s1' = (s1+b) mod M, s2' = (s2+s1') mod M.
// Both inputs are below M, so one conditional subtract per sum suffices.
module adler32_byte_step
  import adler32_chk_pkg::*;
#(
  parameter int unsigned MOD = MOD_BASE
) (
  input  adler32_s_t s,
  input  logic [7:0] b,
  output adler32_s_t nxt
);

  logic [16:0] sum1;
  logic [16:0] sum2;
  logic [15:0] s1_n;
  logic [15:0] s2_n;

  // Two chained 17-bit add / conditional-subtract stages
  always_comb begin
    sum1 = 17'(s.s1) + 17'(b);
    s1_n = (sum1 >= 17'(MOD)) ? 16'(sum1 - 17'(MOD)) : 16'(sum1);
    sum2 = 17'(s.s2) + 17'(s1_n);
    s2_n = (sum2 >= 17'(MOD)) ? 16'(sum2 - 17'(MOD)) : 16'(sum2);
    nxt  = '{s2: s2_n, s1: s1_n};
  end

endmodule

// File: rtl/adler32_chk.sv
// Adler-32 trailer checker for the inflate output stream.
// Build option: define ADLER32_CHK_PAR_EN to add all bytes of a word in one
// cycle (4-stage combinational chain); otherwise one byte per cycle.
module adler32_chk #(
  parameter int unsigned DATA_WD  = adler32_chk_pkg::DATA_WD,
  parameter int unsigned MOD_BASE = adler32_chk_pkg::MOD_BASE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               val_i,
  output logic               rdy_o,
  input  logic [DATA_WD-1:0] dat_i,
  input  logic               lst_i,
  input  logic [1:0]         nbyte_i,
  input  logic               chk_val_i,
  input  logic [DATA_WD-1:0] chk_dat_i,
  output logic               done_o,
  output logic               ok_o,
  output logic               err_o,
  output logic [DATA_WD-1:0] dat_o
);
  import adler32_chk_pkg::*;

  state_t     state;
  adler32_s_t sum;
  logic [2:0] nb;

  assign dat_o = DATA_WD'(sum);

  // Bytes carried by the offered word: 4 unless it is the last one
  assign nb = (lst_i && (nbyte_i != 2'd0)) ? {1'b0, nbyte_i} : 3'd4;

`ifdef ADLER32_CHK_PAR_EN
  adler32_s_t chain [0:4];

  assign chain[0] = sum;

  for (genvar k = 0; k < 4; k++) begin : g_step
    adler32_byte_step #(.MOD(MOD_BASE)) u_step (
      .s   (chain[k]),
      .b   (dat_i[DATA_WD-1-8*k -: 8]),
      .nxt (chain[k+1])
    );
  end
`else
  logic [DATA_WD-1:0] wbuf;
  logic [2:0]         rem;
  logic               last;
  logic [7:0]         byte_c;
  adler32_s_t         step_c;

  // Look-ahead: in ACTV the first byte comes straight from dat_i
  assign byte_c = (state == PROC) ? wbuf[DATA_WD-1 -: 8] : dat_i[DATA_WD-1 -: 8];

  adler32_byte_step #(.MOD(MOD_BASE)) u_step (
    .s   (sum),
    .b   (byte_c),
    .nxt (step_c)
  );
`endif

  // Control FSM, checksum accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sum    <= '0;
      rdy_o  <= 1'b0;
      done_o <= 1'b0;
      ok_o   <= 1'b0;
      err_o  <= 1'b0;
`ifndef ADLER32_CHK_PAR_EN
      wbuf   <= '0;
      rem    <= '0;
      last   <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            sum   <= '{s2: 16'd0, s1: 16'd1};
            ok_o  <= 1'b0;
            err_o <= 1'b0;
            rdy_o <= 1'b1;
            state <= ACTV;
          end
        end
        ACTV: begin
          if (val_i && rdy_o) begin
`ifdef ADLER32_CHK_PAR_EN
            sum <= chain[nb];
            if (lst_i) begin
              rdy_o <= 1'b0;
              state <= CHK;
            end
`else
            sum  <= step_c;
            last <= lst_i;
            if (nb > 3'd1) begin
              wbuf  <= dat_i << 8;
              rem   <= nb - 3'd1;
              rdy_o <= 1'b0;
              state <= PROC;
            end else if (lst_i) begin
              rdy_o <= 1'b0;
              state <= CHK;
            end
`endif
          end else if (chk_val_i) begin
            rdy_o <= 1'b0;
            state <= CHK;
          end
        end
`ifndef ADLER32_CHK_PAR_EN
        PROC: begin
          sum  <= step_c;
          wbuf <= wbuf << 8;
          rem  <= rem - 3'd1;
          if (rem == 3'd1) begin
            if (last) begin
              state <= CHK;
            end else begin
              rdy_o <= 1'b1;
              state <= ACTV;
            end
          end
        end
`endif
        CHK: begin
          if (chk_val_i) begin
            ok_o   <= (dat_o == chk_dat_i);
            err_o  <= (dat_o != chk_dat_i);
            done_o <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/adler32_chk.md
# adler32_chk

Zlib trailer checker for the PNG decode path. It consumes the decompressed byte stream as 32-bit words, MSB byte first, and accumulates the Adler-32 checksum one byte per cycle. It then compares the result against the 4-byte big-endian trailer taken from the zlib stream. It sits after the inflate output and reports pass/fail to the decoder control.

## Interface
Parameters:
- DATA_WD, 32, width of the data word and of the checksum.
- MOD_BASE, 65521, Adler-32 modulus.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  begin a new stream (sampled in IDLE only).
- val_i  in  1  data word valid.
- rdy_o  out  1  word accepted when val_i && rdy_o.
- dat_i  in  32  data bytes, [31:24] first.
- lst_i  in  1  current word is the last one.
- nbyte_i  in  2  valid bytes in the last word; 0 means 4. Ignored when !lst_i.
- chk_val_i  in  1  trailer valid; held high until done_o.
- chk_dat_i  in  32  expected Adler-32 value (s2 in [31:16], s1 in [15:0]).
- done_o  out  1  one-cycle pulse when the compare completes.
- ok_o  out  1  checksum match; held until the next accepted start.
- err_o  out  1  checksum mismatch; held until the next accepted start.
- dat_o  out  32  running checksum, {s2,s1}.

## Operation
- States: IDLE, ACTV, PROC, CHK, DONE.
- IDLE:
  - start_i loads s1=1, s2=0, clears ok_o/err_o, then moves to ACTV.
  - start_i is ignored in all other states.
- ACTV:
  - rdy_o=1.
  - On an accepted word, byte [31:24] is added in the same cycle (look-ahead).
  - If more bytes remain, go to PROC with the byte index set to 1 and the word buffered.
  - Otherwise go to CHK if lst_i was set, or stay in ACTV if not.
  - chk_val_i && !val_i goes to CHK directly; this covers an empty stream or a stream that ended without lst_i. val_i has priority over chk_val_i.
- PROC:
  - rdy_o=0.
  - Adds one buffered byte per cycle.
  - Remaining byte count is 4 for a non-last word and nbyte_i (0 means 4) for the last word.
  - After the final byte, go to ACTV, or to CHK if the word was last.
- CHK:
  - Waits for chk_val_i.
  - Registers ok_o = (dat_o == chk_dat_i) and err_o as its inverse, then goes to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- Arithmetic per byte b:
  - s1' = s1+b, minus MOD_BASE if the result is ≥ MOD_BASE (17-bit sum).
  - s2' = s2+s1', minus MOD_BASE if the result is ≥ MOD_BASE (17-bit sum).
  - A single conditional subtract is sufficient because all operands are below MOD_BASE. No % operator is used.
- Reset values: state IDLE, s1=0, s2=0, so dat_o=0. rdy_o=0, done_o=0, ok_o=0, err_o=0.
- Reset mid-stream aborts immediately; no done_o is produced.

## Timing
- Start accepted at edge T: ACTV at T+1.
- Full last word accepted in cycle T: bytes are added in cycles T..T+3, CHK in T+4.
  - If chk_val_i is already high, done_o is high in T+5 with ok_o/err_o valid in the same cycle.
- Throughput: one word per 4 cycles. The next word can be accepted in the cycle after the final PROC cycle.
- dat_o updates one cycle after each byte is added.

## Configuration
- ADLER32_CHK_PAR_EN defined:
  - ACTV adds all valid bytes of a word in one cycle through a chained 4-stage combinational update.
  - PROC is never entered, and rdy_o stays 1 throughout ACTV.
  - The last word goes straight to CHK.
  - Checksum results are identical to the undefined case.
- ADLER32_CHK_PAR_EN undefined: byte-serial operation as described above.

## Structure
- The shared package holds:
  - the state enum;
  - the MOD_BASE and DATA_WD constants;
  - the `adler32_s_t` struct {s2,s1}.
- Sub-module `adler32_byte_step` is combinational: inputs {s2,s1,b}, output {s2',s1'}.
  - Instantiated once when ADLER32_CHK_PAR_EN is undefined.
  - Instantiated 4 times in a chain when it is defined; the encoder side reuses it.

## Test plan
- "abc": dat_i=0x61626300, lst_i=1, nbyte_i=3, chk_dat_i=0x024D0127 -> done_o pulse, ok_o=1, err_o=0.
- "Wikipedia": words 0x57696B69, 0x70656469, then 0x61000000 with lst_i=1 and nbyte_i=1, chk_dat_i=0x11E60398 -> ok_o=1. Check rdy_o low for 3 cycles after each of the first two words.
- Empty stream: start_i, then chk_val_i with chk_dat_i=0x00000001 and no data -> ok_o=1. Repeat with 0x00000002 -> err_o=1.
- 0xFFFFFFFF with lst_i=1 and nbyte_i=0 -> dat_o=0x09FA03FD. Repeat with a corrupted trailer 0x09FA03FC -> err_o=1.
- Modulo wrap: 70000 bytes of 0xFF, with random val_i gaps -> dat_o[15:0]=0x6E81 and dat_o[31:16] matching the software model.
- rst asserted during PROC -> next cycle IDLE, dat_o=0, no done_o. A following "abc" stream passes.
